shift_op_sequencer: RTL

//  Command scheduler in front of Universal_Shift_Register: queues shift commands, drives set/D/M/enable

---
 rtl/shift_seq_pkg.sv | 34 +++
 rtl/shift_cmd_fifo.sv | 58 +++++
 rtl/shift_op_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared opcodes, FSM state encoding and command-word sizing for the shift
// operation sequencer and its command FIFO.
package shift_seq_pkg;

    localparam logic [2:0] OP_PAR = 3'd1;
    localparam logic [2:0] OP_LSL = 3'd2;
    localparam logic [2:0] OP_LSR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;
    localparam logic [2:0] OP_SER = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_CAPT  = 3'd4,
        ST_RESP  = 3'd5
    } seq_state_t;

    // Queued command word is {op, amt, data}.
    function automatic int cmd_width(input int width);
        return 3 + 2 * (width + 1);
    endfunction

    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd7);
    endfunction

    function automatic logic op_uses_amt(input logic [2:0] op);
        return (op == OP_LSL) || (op == OP_LSR);
    endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO (first-word fall-through) with full/empty/count.
// Pointers wrap modulo DEPTH, which must be a power of two.
module shift_cmd_fifo #(
    parameter int DW    = 35,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/shift_op_sequencer.sv
// Command scheduler in front of a universal shift register: queues commands, drives
// set/D/M/enable, deserialises serial mode. Optional: SHIFT_SEQ_ERR_CHECK_EN.
module shift_op_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH:0]   cmd_amt,
    input  logic [WIDTH:0]   cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH:0]   rsp_data,
    output logic             rsp_err,
    output logic [2:0]       sr_set,
    output logic [WIDTH:0]   sr_d,
    output logic [WIDTH:0]   sr_m,
    output logic             sr_enable,
    input  logic [WIDTH:0]   sr_out
);

    localparam int DW    = WIDTH + 1;
    localparam int CW    = cmd_width(WIDTH);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);

    logic [CW-1:0]    fifo_wdata;
    logic [CW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      unused_fifo_count;
    logic             push;
    logic             pop;

    logic [2:0]       head_op;
    logic [WIDTH:0]   head_amt;
    logic [WIDTH:0]   head_data;

    seq_state_t       state;
    logic             cur_serial;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH:0]   deser;

    assign fifo_wdata = {cmd_op, cmd_amt, cmd_data};
    assign head_op    = fifo_rdata[CW-1 -: 3];
    assign head_amt   = fifo_rdata[2*DW-1 -: DW];
    assign head_data  = fifo_rdata[DW-1:0];

    assign cmd_ready  = ~fifo_full;
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == ST_IDLE) & ~fifo_empty;

    shift_cmd_fifo #(
        .DW    (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res   (res),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

`ifdef SHIFT_SEQ_ERR_CHECK_EN
    logic rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= ST_IDLE;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            sr_set     <= OP_PAR;
            sr_d       <= '0;
            sr_m       <= '0;
            sr_enable  <= 1'b0;
            cur_serial <= 1'b0;
            bit_cnt    <= '0;
            deser      <= '0;
`ifdef SHIFT_SEQ_ERR_CHECK_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    sr_set    <= OP_PAR;
                    sr_d      <= '0;
                    sr_m      <= '0;
                    sr_enable <= 1'b0;
                    if (!fifo_empty) begin
                        cur_serial <= (head_op == OP_SER);
`ifdef SHIFT_SEQ_ERR_CHECK_EN
                        if (op_is_illegal(head_op)) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_err_q <= 1'b1;
                        end else
`endif
                        if (head_op == OP_SER) begin
                            state     <= ST_LOAD;
                            sr_set    <= OP_SER;
                            sr_d      <= head_data;
                            sr_enable <= 1'b1;
                        end else begin
                            // Illegal opcodes only reach here when error checking is off.
                            state  <= ST_ISSUE;
                            sr_set <= op_is_illegal(head_op) ? OP_PAR : head_op;
                            sr_d   <= head_data;
                            sr_m   <= op_uses_amt(head_op) ? head_amt : '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_CAPT;
                end
                ST_LOAD: begin
                    state     <= ST_SHIFT;
                    sr_enable <= 1'b0;
                    bit_cnt   <= '0;
                end
                ST_SHIFT: begin
                    // LSB-first stream: each new bit enters at the MSB.
                    deser   <= {sr_out[0], deser[WIDTH:1]};
                    bit_cnt <= bit_cnt + BIT_ONE;
                    if (bit_cnt == BIT_LAST) state <= ST_CAPT;
                end
                ST_CAPT: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= cur_serial ? deser : sr_out;
`ifdef SHIFT_SEQ_ERR_CHECK_EN
                    rsp_err_q <= 1'b0;
`endif
                    sr_set    <= OP_PAR;
                    sr_d      <= '0;
                    sr_m      <= '0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
